mem_access: RTL and testbench

//  Memory-access (MEM) stage. Sits between ex_mem and mem_wb.

---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/mem_access_if.sv | 36 +++
 rtl/mem_watchdog.sv | 25 ++
 rtl/mem_access.sv | 143 ++++++++++++++
 tb/tb_mem_access.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM stage: FSM states, decoded operation, reset words.
package mem_access_pkg;

    typedef enum logic [1:0] {
        MEM_IDLE,
        MEM_WAIT,
        MEM_DONE
    } mem_state_t;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_STORE,
        OP_LOAD,
        OP_OUT,
        OP_IN
    } mem_op_t;

    localparam logic [31:0] ZERO_WORD     = '0;
    localparam logic [4:0]  NOP_REG_ADDR  = '0;
    localparam logic        WRITE_DISABLE = 1'b0;

    // Store beats load beats OUT beats IN; memW & memR together resolves to the store.
    function automatic mem_op_t pick_op(input logic mem_w, input logic mem_r,
                                        input logic out_op, input logic in_op);
        if (mem_w)       return OP_STORE;
        else if (mem_r)  return OP_LOAD;
        else if (out_op) return OP_OUT;
        else if (in_op)  return OP_IN;
        else             return OP_NONE;
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus (req/ack) and I/O port (valid/ready) signals of the MEM stage.
interface mem_access_if;

    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [31:0] dbus_rdata;
    logic        dbus_ack;

    logic [31:0] io_in_data;
    logic        io_in_valid;
    logic        io_in_ready;
    logic [31:0] io_out_data;
    logic        io_out_valid;
    logic        io_out_ready;

    modport master (
        output dbus_req, dbus_we, dbus_addr, dbus_wdata,
        input  dbus_rdata, dbus_ack,
        input  io_in_data, io_in_valid,
        output io_in_ready,
        output io_out_data, io_out_valid,
        input  io_out_ready
    );

    modport slave (
        input  dbus_req, dbus_we, dbus_addr, dbus_wdata,
        output dbus_rdata, dbus_ack,
        output io_in_data, io_in_valid,
        input  io_in_ready,
        input  io_out_data, io_out_valid,
        output io_out_ready
    );

endinterface

// File: rtl/mem_watchdog.sv
// Wait-state watchdog for the MEM stage; only present when MEM_TIMEOUT_EN is defined.
`ifdef MEM_TIMEOUT_EN
module mem_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count;

    // Counts completed wait cycles; expires during the TIMEOUT_CYCLES-th one.
    always_ff @(posedge clk) begin
        if (rst || !run) count <= '0;
        else             count <= count + 8'd1;
    end

    assign expire = run && (count == LAST);

endmodule
`endif

// File: rtl/mem_access.sv
// MEM stage: performs load/store over the data bus or IN/OUT over the I/O handshake, stalling
// the pipeline until it completes. Optional watchdog abort under MEM_TIMEOUT_EN.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          wd_i,
    input  logic                wreg_i,
    input  logic [31:0]         wdata_i,
    input  logic                memW_i,
    input  logic                memR_i,
    input  logic [31:0]         addr_i,
    input  logic                in_i,
    input  logic                out_i,
    mem_access_if.master        bus,
    output logic                stallreq_mem,
    output logic [4:0]          wd_o,
    output logic                wreg_o,
    output logic [31:0]         wdata_o,
    output logic                mem_err
);

    mem_state_t  state, state_nx;
    mem_op_t     op;
    logic        active;
    logic        handshake;
    logic        expire;
    logic        abort_q, abort_nx;
    logic [31:0] result_q, result_nx;

    assign op = pick_op(memW_i, memR_i, out_i, in_i);

    assign bus.dbus_we     = memW_i & bus.dbus_req;
    assign bus.dbus_addr   = addr_i;
    assign bus.dbus_wdata  = wdata_i;
    assign bus.io_out_data = wdata_i;

    always_comb begin
        state_nx         = state;
        result_nx        = result_q;
        abort_nx         = 1'b0;
        active           = 1'b0;
        handshake        = 1'b0;
        bus.dbus_req     = 1'b0;
        bus.io_out_valid = 1'b0;
        bus.io_in_ready  = 1'b0;
        stallreq_mem     = 1'b0;
        wd_o             = wd_i;
        wreg_o           = wreg_i;
        wdata_o          = wdata_i;

        unique case (state)
            MEM_IDLE, MEM_WAIT: begin
                active       = (state == MEM_WAIT) || (op != OP_NONE);
                stallreq_mem = active;
                unique case (op)
                    OP_STORE, OP_LOAD: begin
                        bus.dbus_req = active;
                        handshake    = bus.dbus_ack;
                    end
                    OP_OUT: begin
                        bus.io_out_valid = active;
                        handshake        = bus.io_out_ready;
                    end
                    OP_IN: begin
                        bus.io_in_ready = active;
                        handshake       = bus.io_in_valid;
                    end
                    default: handshake = 1'b0;
                endcase
                if (active) begin
                    if (handshake) begin
                        state_nx  = MEM_DONE;
                        result_nx = (op == OP_LOAD) ? bus.dbus_rdata :
                                    (op == OP_IN)   ? bus.io_in_data : wdata_i;
                    end else if (expire) begin
                        state_nx  = MEM_DONE;
                        result_nx = ZERO_WORD;
                        abort_nx  = 1'b1;
                    end else begin
                        state_nx  = MEM_WAIT;
                    end
                end
            end
            MEM_DONE: begin
                wdata_o  = result_q;
                if (abort_q) wreg_o = WRITE_DISABLE;
                state_nx = MEM_IDLE;
            end
            default: state_nx = MEM_IDLE;
        endcase

        // Reset overrides every output combinationally so a mid-access rst drops requests at once.
        if (rst) begin
            state_nx         = MEM_IDLE;
            abort_nx         = 1'b0;
            bus.dbus_req     = 1'b0;
            bus.io_out_valid = 1'b0;
            bus.io_in_ready  = 1'b0;
            stallreq_mem     = 1'b0;
            wd_o             = NOP_REG_ADDR;
            wreg_o           = WRITE_DISABLE;
            wdata_o          = ZERO_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= MEM_IDLE;
            result_q <= ZERO_WORD;
            abort_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            result_q <= result_nx;
            abort_q  <= abort_nx;
        end
    end

`ifdef MEM_TIMEOUT_EN
    logic err_q;

    mem_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .run    (state == MEM_WAIT),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | abort_nx;
    end

    assign mem_err = err_q & ~rst;
`else
    assign expire  = 1'b0;
    assign mem_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access; expectations come from a transaction-level
// model (winning op, stall = latency + 1, result by op kind). Covers MEM_TIMEOUT_EN when defined.
module tb_mem_access;

    localparam int K_NONE = 0, K_ST = 1, K_LD = 2, K_OUT = 3, K_IN = 4;
`ifdef MEM_TIMEOUT_EN
    localparam int unsigned LAT_MAX = 4;
`else
    localparam int unsigned LAT_MAX = 6;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic        memW_i, memR_i, in_i, out_i;
    logic [31:0] addr_i;
    logic        stallreq_mem;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        mem_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    mem_access_if bus ();

    mem_access #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .memW_i       (memW_i),
        .memR_i       (memR_i),
        .addr_i       (addr_i),
        .in_i         (in_i),
        .out_i        (out_i),
        .bus          (bus),
        .stallreq_mem (stallreq_mem),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .mem_err      (mem_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_ops(input logic w, input logic r, input logic o, input logic i);
        memW_i = w; memR_i = r; out_i = o; in_i = i;
    endtask

    task automatic quiet_bus();
        bus.dbus_ack = 1'b0; bus.io_in_valid = 1'b0; bus.io_out_ready = 1'b0;
        bus.dbus_rdata = $urandom; bus.io_in_data = $urandom;
    endtask

    // No memory/IO op: outputs mirror inputs, no stall; stray handshakes must be ignored.
    task automatic alu(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                       input int unsigned cycles, input string tag);
        set_ops(0, 0, 0, 0);
        wd_i = wd; wreg_i = wreg; wdata_i = wdata; addr_i = $urandom;
        for (int unsigned c = 0; c < cycles; c++) begin
            quiet_bus();
            bus.dbus_ack = 1'($urandom_range(0, 1));
            bus.io_in_valid = 1'($urandom_range(0, 1));
            bus.io_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check({tag, ".stall"}, 32'(stallreq_mem), 32'd0);
            check({tag, ".req"}, 32'({bus.dbus_req, bus.io_out_valid, bus.io_in_ready}), 32'd0);
            check({tag, ".wd"}, 32'(wd_o), 32'(wd));
            check({tag, ".wreg"}, 32'(wreg_o), 32'(wreg));
            check({tag, ".wdata"}, wdata_o, wdata);
            @(posedge clk); #1;
        end
    endtask

    // One instruction whose handshake arrives lat cycles after the request cycle.
    task automatic access(input logic w, input logic r, input logic o, input logic i,
                          input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic [31:0] addr, input int unsigned lat,
                          input logic [31:0] rdata, input string tag);
        int kind;
        logic [31:0] exp_res;
        int unsigned stalls, reqs;
        logic req;
        kind = w ? K_ST : r ? K_LD : o ? K_OUT : i ? K_IN : K_NONE;
        exp_res = (kind == K_LD || kind == K_IN) ? rdata : wdata;
        set_ops(w, r, o, i);
        wd_i = wd; wreg_i = wreg; wdata_i = wdata; addr_i = addr;
        stalls = 0; reqs = 0;
        for (int unsigned k = 0; k <= lat + 1; k++) begin
            quiet_bus();
            if (k == lat) begin
                bus.dbus_rdata = rdata; bus.io_in_data = rdata;
                bus.dbus_ack     = (kind == K_ST || kind == K_LD);
                bus.io_out_ready = (kind == K_OUT);
                bus.io_in_valid  = (kind == K_IN);
            end else if (k == lat + 1) begin
                bus.dbus_ack = 1'($urandom_range(0, 1));
                bus.io_in_valid = 1'($urandom_range(0, 1));
                bus.io_out_ready = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            req = (kind == K_ST || kind == K_LD) ? bus.dbus_req :
                  (kind == K_OUT) ? bus.io_out_valid : bus.io_in_ready;
            stalls += 32'(stallreq_mem);
            reqs   += 32'(req);
            if (k <= lat) begin
                check({tag, ".stall"}, 32'(stallreq_mem), 32'd1);
                check({tag, ".req"}, 32'(req), 32'd1);
                if (kind == K_ST || kind == K_LD) begin
                    check({tag, ".addr"}, bus.dbus_addr, addr);
                    check({tag, ".we"}, 32'(bus.dbus_we), 32'(kind == K_ST));
                    if (kind == K_ST) check({tag, ".bwdata"}, bus.dbus_wdata, wdata);
                end else if (kind == K_OUT) begin
                    check({tag, ".odata"}, bus.io_out_data, wdata);
                end
            end else begin
                check({tag, ".done_req"}, 32'({bus.dbus_req, bus.io_out_valid, bus.io_in_ready}), 32'd0);
                check({tag, ".done_we"}, 32'(bus.dbus_we), 32'd0);
                check({tag, ".wd"}, 32'(wd_o), 32'(wd));
                check({tag, ".wreg"}, 32'(wreg_o), 32'(wreg));
                check({tag, ".wdata"}, wdata_o, exp_res);
            end
            @(posedge clk); #1;
        end
        check({tag, ".stall_cycles"}, stalls, lat + 1);
        check({tag, ".req_cycles"}, reqs, lat + 1);
        check({tag, ".err"}, 32'(mem_err), 32'd0);
    endtask

    initial begin
        logic [3:0] opbits;
        rst = 1'b1;
        set_ops(0, 0, 0, 0);
        wd_i = 5'd9; wreg_i = 1'b1; wdata_i = 32'hFFFF_0000; addr_i = '0;
        quiet_bus();
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset.wd", 32'(wd_o), 32'd0);
        check("reset.wreg", 32'(wreg_o), 32'd0);
        check("reset.wdata", wdata_o, 32'd0);
        check("reset.stall", 32'(stallreq_mem), 32'd0);
        check("reset.err", 32'(mem_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        alu(5'd3, 1'b1, 32'h1234, 3, "alu");
        access(0, 1, 0, 0, 5'd4, 1'b1, 32'h0, 32'h100, 3, 32'hDEADBEEF, "load");
        access(1, 0, 0, 0, 5'd0, 1'b0, 32'hA5A5A5A5, 32'h40, 0, 32'h0, "store");
        alu(5'd1, 1'b0, 32'h77, 1, "after_store");
        access(0, 0, 1, 0, 5'd0, 1'b0, 32'hC0FFEE01, 32'h8, 2, 32'h0, "out");
        access(0, 0, 0, 1, 5'd7, 1'b1, 32'h0, 32'h9, 0, 32'h13579BDF, "in");
        access(1, 1, 0, 0, 5'd2, 1'b0, 32'h5555AAAA, 32'h44, 1, 32'h11111111, "st_ld");
        access(0, 1, 1, 1, 5'd5, 1'b1, 32'h0, 32'h48, 2, 32'h22222222, "ld_prio");

        // Reset during WAIT: requests vanish that cycle, machine restarts in IDLE.
        set_ops(0, 1, 0, 0);
        wd_i = 5'd6; wreg_i = 1'b1; wdata_i = 32'h0; addr_i = 32'h200;
        quiet_bus();
        @(negedge clk);
        check("rstw.stall0", 32'(stallreq_mem), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstw.stall1", 32'(stallreq_mem), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstw.req", 32'({bus.dbus_req, bus.io_out_valid, bus.io_in_ready}), 32'd0);
        check("rstw.stall", 32'(stallreq_mem), 32'd0);
        check("rstw.wd", 32'(wd_o), 32'd0);
        check("rstw.wreg", 32'(wreg_o), 32'd0);
        check("rstw.wdata", wdata_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        alu(5'd8, 1'b1, 32'hBEEF0001, 2, "rstw_idle");

        for (int n = 0; n < 40; n++) begin
            opbits = 4'($urandom_range(0, 15));
            if (opbits == 4'd0)
                alu(5'($urandom), 1'($urandom), $urandom, 1, "rnd_alu");
            else
                access(opbits[3], opbits[2], opbits[1], opbits[0], 5'($urandom), 1'($urandom),
                       $urandom, $urandom, $urandom_range(0, LAT_MAX), $urandom, "rnd");
            if ($urandom_range(0, 3) == 0)
                alu(5'($urandom), 1'($urandom), $urandom, 1, "rnd_gap");
        end

`ifdef MEM_TIMEOUT_EN
        // No ack: four WAIT cycles, then forced DONE with zero result and write suppressed.
        set_ops(0, 1, 0, 0);
        wd_i = 5'd10; wreg_i = 1'b1; wdata_i = 32'h0; addr_i = 32'h300;
        for (int unsigned k = 0; k <= 5; k++) begin
            quiet_bus();
            @(negedge clk);
            if (k <= 4) begin
                check("tmo.stall", 32'(stallreq_mem), 32'd1);
                check("tmo.req", 32'(bus.dbus_req), 32'd1);
                check("tmo.err0", 32'(mem_err), 32'd0);
            end else begin
                check("tmo.done_stall", 32'(stallreq_mem), 32'd0);
                check("tmo.wdata", wdata_o, 32'd0);
                check("tmo.wreg", 32'(wreg_o), 32'd0);
                check("tmo.err1", 32'(mem_err), 32'd1);
            end
            @(posedge clk); #1;
        end
        alu(5'd1, 1'b1, 32'h99, 3, "tmo_after");
        check("tmo.sticky", 32'(mem_err), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("tmo.cleared", 32'(mem_err), 32'd0);
        @(posedge clk); #1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
